// File: rtl/ln_center_var_pkg.sv
// Shared constants and lane helpers for the LayerNorm mean/centering/variance blocks.
package ln_center_var_pkg;

    localparam int unsigned LANES  = 16;
    localparam int unsigned Q_FRAC = 8;
    localparam int unsigned LANE_W = 16;
    localparam int unsigned XC_W   = 17;
    localparam int unsigned SQ_W   = 24;
    localparam int unsigned SUM_W  = SQ_W + 4;

    typedef logic [LANE_W-1:0] lane_t;
    typedef logic [XC_W-1:0]   xc_t;
    typedef logic [SQ_W-1:0]   sq_t;

    function automatic lane_t get_lane(input logic [LANES*LANE_W-1:0] v, input int unsigned i);
        return v[i*LANE_W +: LANE_W];
    endfunction

    function automatic xc_t get_xc(input logic [LANES*XC_W-1:0] v, input int unsigned i);
        return v[i*XC_W +: XC_W];
    endfunction

endpackage

// File: rtl/ln_sq_tree.sv
// Four-stage registered adder tree: sixteen unsigned squares in, 28-bit sum out.
module ln_sq_tree
    import ln_center_var_pkg::*;
(
    input  logic                  clk,
    input  logic [LANES*SQ_W-1:0] i_sq,
    output logic [SUM_W-1:0]      o_sum
);

    localparam int unsigned W1 = SQ_W + 1;
    localparam int unsigned W2 = SQ_W + 2;
    localparam int unsigned W3 = SQ_W + 3;

    logic [8*W1-1:0]  r_l1;
    logic [4*W2-1:0]  r_l2;
    logic [2*W3-1:0]  r_l3;
    logic [SUM_W-1:0] r_l4;

    // Each level widens by one bit so no partial sum can overflow.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 8; i++)
            r_l1[i*W1 +: W1] <= {1'b0, i_sq[(2*i)*SQ_W +: SQ_W]} + {1'b0, i_sq[(2*i+1)*SQ_W +: SQ_W]};
        for (int unsigned i = 0; i < 4; i++)
            r_l2[i*W2 +: W2] <= {1'b0, r_l1[(2*i)*W1 +: W1]} + {1'b0, r_l1[(2*i+1)*W1 +: W1]};
        for (int unsigned i = 0; i < 2; i++)
            r_l3[i*W3 +: W3] <= {1'b0, r_l2[(2*i)*W2 +: W2]} + {1'b0, r_l2[(2*i+1)*W2 +: W2]};
        r_l4 <= {1'b0, r_l3[0 +: W3]} + {1'b0, r_l3[W3 +: W3]};
    end

    assign o_sum = r_l4;

endmodule

// File: rtl/ln_center_var.sv
// Centers a 16-lane Q8.8 vector on the mean unit's result and computes its population variance.
module ln_center_var #(
    parameter int unsigned MEAN_LAT = 5,
    parameter int unsigned LANES    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LANES*16-1:0]   x_in_flat,
    input  logic                  in_valid,
    input  logic [15:0]           mean_in,
    output logic [LANES*17-1:0]   xc_flat,
    output logic [23:0]           var_out,
    output logic                  out_valid
);

    import ln_center_var_pkg::*;

    localparam int unsigned VLEN   = MEAN_LAT + 8;
    localparam int unsigned XC_DLY = 5;

    logic [VLEN-1:0]         r_vld;
    logic [LANES*LANE_W-1:0] r_x  [0:MEAN_LAT];
    logic [LANES*XC_W-1:0]   r_d;
    logic [LANES*XC_W-1:0]   r_dd [0:XC_DLY-1];
    logic [LANES*SQ_W-1:0]   r_sq;
    logic [LANES*XC_W-1:0]   r_xc;
    logic [23:0]             r_var;

    logic [LANES*XC_W-1:0]   w_d;
    logic [LANES*SQ_W-1:0]   w_sq;
    logic [SUM_W-1:0]        w_sum;
    logic                    w_unused_bits;

    // r_vld[0] is the sampling register; the top bit is out_valid itself.
    always_ff @(posedge clk) begin
        if (rst) r_vld <= '0;
        else     r_vld <= {r_vld[VLEN-2:0], in_valid};
    end

    // r_x[0] samples alongside the mean unit's input register, so r_x[MEAN_LAT]
    // presents the vector in the same cycle mean_in becomes valid.
    always_ff @(posedge clk) begin
        r_x[0] <= x_in_flat;
        for (int unsigned i = 1; i <= MEAN_LAT; i++)
            r_x[i] <= r_x[i-1];
        r_d     <= w_d;
        r_sq    <= w_sq;
        r_dd[0] <= r_d;
        for (int unsigned i = 1; i < XC_DLY; i++)
            r_dd[i] <= r_dd[i-1];
    end

    always_comb begin
        w_d = '0;
        for (int unsigned i = 0; i < LANES; i++)
            w_d[i*XC_W +: XC_W] = xc_t'({1'b0, get_lane(r_x[MEAN_LAT], i)}) - xc_t'({1'b0, mean_in});
    end

    always_comb begin : square
        xc_t         lane;
        xc_t         mag;
        logic [31:0] prod;
        w_sq          = '0;
        w_unused_bits = 1'b0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane = get_xc(r_d, i);
            mag  = lane[XC_W-1] ? (~lane + xc_t'(1)) : lane;
            prod = 32'(mag[15:0]) * 32'(mag[15:0]);
            w_sq[i*SQ_W +: SQ_W] = prod[31:Q_FRAC];
            w_unused_bits = w_unused_bits ^ mag[XC_W-1] ^ (^prod[Q_FRAC-1:0]);
        end
    end

    ln_sq_tree u_tree (
        .clk   (clk),
        .i_sq  (r_sq),
        .o_sum (w_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_var <= '0;
            r_xc  <= '0;
        end else if (r_vld[VLEN-2]) begin
            r_var <= w_sum[SUM_W-1:4];
            r_xc  <= r_dd[XC_DLY-1];
        end
    end

    assign out_valid = r_vld[VLEN-1];
    assign var_out   = r_var;
    assign xc_flat   = r_xc;

endmodule

// File: tb/tb_ln_center_var.sv
// Scoreboard bench for ln_center_var with a behavioural mean-unit model driving mean_in.
module tb_ln_center_var;

    localparam int unsigned LAT = 12;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] x_in_flat;
    logic         in_valid;
    logic [15:0]  mean_in;
    logic [271:0] xc_flat;
    logic [23:0]  var_out;
    logic         out_valid;

    typedef struct {
        logic [271:0] xc;
        logic [23:0]  v;
        int unsigned  cyc;
    } exp_t;

    exp_t         q[$];
    int           checks   = 0;
    int           failures = 0;
    int unsigned  cyc      = 0;
    logic [15:0]  mp [0:5];
    logic [271:0] last_xc  = '0;
    logic [23:0]  last_var = '0;

    ln_center_var #(.MEAN_LAT(5), .LANES(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .x_in_flat (x_in_flat),
        .in_valid  (in_valid),
        .mean_in   (mean_in),
        .xc_flat   (xc_flat),
        .var_out   (var_out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] ref_mean(input logic [255:0] v);
        int unsigned s = 0;
        for (int i = 0; i < 16; i++) s += v[i*16 +: 16];
        return 16'(s / 16);
    endfunction

    // Mean unit: input register plus five stages; only its output register is reset.
    always @(posedge clk) begin
        mp[0] <= ref_mean(x_in_flat);
        for (int i = 1; i < 5; i++) mp[i] <= mp[i-1];
        mp[5] <= rst ? 16'h0 : mp[4];
    end
    assign mean_in = mp[5];

    task automatic chk(input string name, input logic [271:0] act, input logic [271:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [271:0] xc, input logic [23:0] v);
        exp_t e;
        e.xc  = xc;
        e.v   = v;
        e.cyc = cyc + LAT + 1;
        q.push_back(e);
    endtask

    task automatic ref_push(input logic [255:0] v);
        logic [15:0]  m;
        logic [271:0] xc;
        longint       sum;
        longint       d;
        m   = ref_mean(v);
        sum = 0;
        for (int i = 0; i < 16; i++) begin
            d = longint'(v[i*16 +: 16]) - longint'(m);
            xc[i*17 +: 17] = d[16:0];
            sum += (d * d) / 256;
        end
        push_exp(xc, 24'(sum / 16));
    endtask

    task automatic step(input logic [255:0] v, input logic vld);
        x_in_flat = v;
        in_valid  = vld;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (cyc > 0) begin
            if (rst) begin
                last_xc  = '0;
                last_var = '0;
            end else if (out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_out_valid: got 1 expected 0 at cycle %0d", cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("latency_cycle", 272'(cyc), 272'(e.cyc));
                    chk("xc_flat", xc_flat, e.xc);
                    chk("var_out", 272'(var_out), 272'(e.v));
                end
                last_xc  = xc_flat;
                last_var = var_out;
            end else begin
                chk("hold_xc", xc_flat, last_xc);
                chk("hold_var", 272'(var_out), 272'(last_var));
            end
        end
    end

    initial begin
        logic [255:0] v;
        logic [271:0] xe;
        int unsigned  waited;

        rst       = 1'b1;
        in_valid  = 1'b0;
        x_in_flat = '0;
        for (int i = 0; i < 6; i++) mp[i] = '0;

        for (int r = 0; r < 2; r++) begin
            @(posedge clk);
            #1;
            chk("rst_out_valid", 272'(out_valid), 272'(0));
            chk("rst_var_out", 272'(var_out), 272'(0));
            chk("rst_xc_flat", xc_flat, '0);
        end
        rst = 1'b0;

        // all lanes 1.0
        for (int i = 0; i < 16; i++) v[i*16 +: 16] = 16'h0100;
        push_exp('0, 24'h000000);
        step(v, 1'b1);

        // even lanes 2.0, odd lanes 0
        for (int i = 0; i < 16; i++) begin
            v[i*16 +: 16]  = (i % 2 == 0) ? 16'h0200 : 16'h0000;
            xe[i*17 +: 17] = (i % 2 == 0) ? 17'h00100 : 17'h1FF00;
        end
        push_exp(xe, 24'h000100);
        step(v, 1'b1);

        // single saturated lane
        v = '0;
        v[15:0] = 16'hFFFF;
        for (int i = 0; i < 16; i++) xe[i*17 +: 17] = (i == 0) ? 17'h0F000 : 17'h1F001;
        push_exp(xe, 24'h0EFFE2);
        step(v, 1'b1);

        for (int i = 0; i < 4; i++) step('0, 1'b0);

        for (int n = 0; n < 25; n++) begin
            if (n == 20) for (int g = 0; g < 3; g++) step('0, 1'b0);
            for (int i = 0; i < 16; i++)
                v[i*16 +: 16] = (n % 3 == 0) ? 16'($urandom_range(0, 1023)) : 16'($urandom);
            ref_push(v);
            step(v, 1'b1);
        end

        waited = 0;
        while (q.size() != 0 && waited < 60) begin
            step('0, 1'b0);
            waited++;
        end
        chk("drain_random", 272'(q.size()), 272'(0));

        // mid-flight reset: this vector must never emerge
        for (int i = 0; i < 16; i++) v[i*16 +: 16] = 16'($urandom);
        step(v, 1'b1);
        step('0, 1'b0);
        step('0, 1'b0);
        rst = 1'b1;
        step('0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) step('0, 1'b0);

        for (int i = 0; i < 16; i++) v[i*16 +: 16] = 16'($urandom);
        ref_push(v);
        step(v, 1'b1);
        waited = 0;
        while (q.size() != 0 && waited < 40) begin
            step('0, 1'b0);
            waited++;
        end
        chk("drain_after_rst", 272'(q.size()), 272'(0));
        step('0, 1'b0);
        step('0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
